// File: rtl/ring_freq_counter_if.sv
// Measurement bus for ring_freq_counter: ring input and hold in, count/valid/overflow out.
interface ring_freq_counter_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             ring_in;
  logic             hold;
  logic [CNT_W-1:0] bin;
  logic             valid;
  logic             ovf;

  modport master (input ring_in, hold, output bin, valid, ovf);
  modport slave  (output ring_in, hold, input bin, valid, ovf);
endinterface

// File: rtl/ring_freq_counter.sv
// Ring-oscillator frequency meter: counts synchronised ring_in rises per GATE_CYCLES window.
// Optional FREQ_CLAMP_9999_EN limits the published count to 9999 for a 4-digit BCD display.
module ring_freq_counter #(
  parameter int unsigned GATE_CYCLES = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  ring_freq_counter_if.master bus
);

  typedef enum logic {ARM, RUN} state_t;

  localparam logic [23:0]      LAST = 24'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAXC = '1;

  state_t           state, state_n;
  logic [1:0]       arm_cnt, arm_cnt_n;
  logic             s1, s2, s3, edge_now;
  logic [CNT_W-1:0] edge_cnt, edge_sum;
  logic [23:0]      gate_cnt;
  logic             win_ovf, clamp, last;
  logic [CNT_W-1:0] res;
  logic             res_ovf, pend;

  assign edge_now = s2 & ~s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARM;
      arm_cnt <= '0;
    end else begin
      state   <= state_n;
      arm_cnt <= arm_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    arm_cnt_n = arm_cnt;
    last      = 1'b0;
    clamp     = 1'b0;
    edge_sum  = edge_cnt;
    case (state)
      ARM: begin
        arm_cnt_n = arm_cnt + 2'd1;
        if (arm_cnt == 2'd2) begin
          state_n   = RUN;
          arm_cnt_n = '0;
        end
      end
      RUN: begin
        last = (gate_cnt == LAST);
        if (edge_now) begin
          if (edge_cnt == MAXC) clamp = 1'b1;
          else                  edge_sum = edge_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.ring_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Window result is captured on the closing gate cycle and published one clock later.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt  <= '0;
      gate_cnt  <= '0;
      win_ovf   <= 1'b0;
      res       <= '0;
      res_ovf   <= 1'b0;
      pend      <= 1'b0;
      bus.bin   <= '0;
      bus.valid <= 1'b0;
      bus.ovf   <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      pend      <= 1'b0;
      if (state == RUN) begin
        if (last) begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          win_ovf  <= 1'b0;
          res      <= edge_sum;
          res_ovf  <= win_ovf | clamp;
          pend     <= ~bus.hold;
        end else begin
          gate_cnt <= gate_cnt + 24'd1;
          edge_cnt <= edge_sum;
          win_ovf  <= win_ovf | clamp;
        end
      end
      if (pend) begin
        bus.valid <= 1'b1;
`ifdef FREQ_CLAMP_9999_EN
        if (32'(res) > 32'd9999) begin
          bus.bin <= CNT_W'(32'd9999);
          bus.ovf <= 1'b1;
        end else begin
          bus.bin <= res;
          bus.ovf <= res_ovf;
        end
`else
        bus.bin <= res;
        bus.ovf <= res_ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ring_freq_counter.sv
// Directed bench for ring_freq_counter: main, 4-bit saturation and 30000-cycle clamp instances.
module tb_ring_freq_counter;

  logic clk = 1'b0;
  logic rst, rst_c;
  logic rel = 1'b0;
  logic sat_done = 1'b0, clamp_done = 1'b0;
  int   checks = 0, failures = 0;
  int   per[3];
  logic lvl[3];

  always #5 clk = ~clk;

  ring_freq_counter_if #(.CNT_W(16)) m ();
  ring_freq_counter_if #(.CNT_W(4))  s ();
  ring_freq_counter_if #(.CNT_W(16)) c ();

  ring_freq_counter #(.GATE_CYCLES(100),   .CNT_W(16)) u_main  (.clk(clk), .rst(rst),   .bus(m));
  ring_freq_counter #(.GATE_CYCLES(100),   .CNT_W(4))  u_sat   (.clk(clk), .rst(rst),   .bus(s));
  ring_freq_counter #(.GATE_CYCLES(30000), .CNT_W(16)) u_clamp (.clk(clk), .rst(rst_c), .bus(c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Sequencing processes resume 2 time units after each posedge; the ring generator 1 unit after.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int sel, input int lim, output int k);
    logic v;
    k = 0;
    do begin
      tick();
      k++;
      v = (sel == 0) ? m.valid : (sel == 1) ? s.valid : c.valid;
    end while (!v && k < lim);
  endtask

  // A level written to lvl[] during tick n reaches ring_in after edge n+1.
  initial begin
    int   ph[3];
    logic r[3];
    for (int i = 0; i < 3; i++) ph[i] = 0;
    m.ring_in = 1'b0;
    s.ring_in = 1'b0;
    c.ring_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (per[i] == 0) r[i] = lvl[i];
        else begin
          ph[i] = (ph[i] + 1) % per[i];
          r[i]  = (ph[i] < per[i] / 2);
        end
      end
      m.ring_in = r[0];
      s.ring_in = r[1];
      c.ring_in = r[2];
    end
  end

  initial begin
    int k, vcnt;
    rst = 1'b1; rst_c = 1'b1;
    m.hold = 1'b0; s.hold = 1'b0; c.hold = 1'b0;
    per[0] = 2; per[1] = 4; per[2] = 2;
    lvl[0] = 1'b0; lvl[1] = 1'b0; lvl[2] = 1'b0;
    repeat (2) tick();
    check_eq("rst_bin",   32'(m.bin), 0);
    check_eq("rst_valid", 32'(m.valid), 0);
    check_eq("rst_ovf",   32'(m.ovf), 0);

    per[0] = 10;
    rst = 1'b0; rst_c = 1'b0; rel = 1'b1;
    wait_valid(0, 200, k);
    check_eq("first_lat", k, 104);
    check_eq("w0_bin", 32'(m.bin), 10);
    check_eq("w0_ovf", 32'(m.ovf), 0);
    wait_valid(0, 200, k);
    check_eq("w1_gap", k, 100);
    check_eq("w1_bin", 32'(m.bin), 10);

    m.hold = 1'b1;
    per[0] = 20;
    vcnt = 0;
    repeat (200) begin
      tick();
      if (m.valid) vcnt++;
    end
    check_eq("hold_valids", vcnt, 0);
    check_eq("hold_bin", 32'(m.bin), 10);
    m.hold = 1'b0;
    wait_valid(0, 200, k);
    check_eq("unhold_gap", k, 100);
    check_eq("unhold_bin", 32'(m.bin), 5);
    check_eq("unhold_ovf", 32'(m.ovf), 0);

    per[0] = 0; lvl[0] = 1'b0;
    wait_valid(0, 200, k);
    check_eq("quiet_gap", k, 100);
    repeat (95) tick();
    lvl[0] = 1'b1;
    wait_valid(0, 200, k);
    check_eq("lastedge_k", k, 5);
    check_eq("lastedge_bin", 32'(m.bin), 1);
    wait_valid(0, 200, k);
    check_eq("after_edge_bin", 32'(m.bin), 0);

    repeat (30) tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_bin",   32'(m.bin), 0);
    check_eq("midrst_valid", 32'(m.valid), 0);
    rst = 1'b0;
    wait_valid(0, 200, k);
    check_eq("rerun_lat", k, 104);
    check_eq("high_at_rel_bin", 32'(m.bin), 0);

    k = 0;
    while (!(sat_done && clamp_done) && k < 40000) begin
      tick();
      k++;
    end
    check_eq("side_done", 32'(sat_done && clamp_done), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int k;
    wait (rel);
    wait_valid(1, 200, k);
    check_eq("sat_lat", k, 104);
    check_eq("sat_bin", 32'(s.bin), 15);
    check_eq("sat_ovf", 32'(s.ovf), 1);
    per[1] = 20;
    wait_valid(1, 200, k);
    wait_valid(1, 200, k);
    check_eq("sat_rec_bin", 32'(s.bin), 5);
    check_eq("sat_rec_ovf", 32'(s.ovf), 0);
    sat_done = 1'b1;
  end

  initial begin
    int k;
    wait (rel);
    wait_valid(2, 30100, k);
    check_eq("clamp_lat", k, 30004);
`ifdef FREQ_CLAMP_9999_EN
    check_eq("clamp_bin", 32'(c.bin), 9999);
    check_eq("clamp_ovf", 32'(c.ovf), 1);
`else
    check_eq("clamp_bin", 32'(c.bin), 15000);
    check_eq("clamp_ovf", 32'(c.ovf), 0);
`endif
    clamp_done = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
